diff_ctrl: RTL and testbench
============================

# diff_ctrl

Parametrised difficulty and tempo controller for the game core. It replaces the fixed three-level selector with an N-level table and up/down selection, and adds an in-game auto-ramp that tightens tempo on hit streaks. It also has an internal beat-tick generator, so downstream note-scroll logic consumes a single `tick` pulse instead of its own speed counter. It sits between the button/mode front end and the note scroller.

## Interface
Parameters:
- `NUM_LEVELS`, 3: number of difficulty levels, ≥2.
- `SPEED_W`, 23: width of speed and period values.
- `BASE_SPEED`, 6000000: period, in clk cycles, at level 1.
- `SPEED_STEP`, 2000000: period reduction per level. Elaboration fails unless `BASE_SPEED > (NUM_LEVELS-1)*SPEED_STEP`.
- `WRAP`, 1: 1 makes level selection wrap at the ends; 0 makes it saturate.
- `DIFF_MODE`, 3'd3: `mode` value in which level selection is enabled.
- `STREAK_LEN`, 8: consecutive hits per ramp step.
- `RAMP_STEP`, 250000: period reduction per ramp step.
- `MIN_SPEED`, 1000000: floor for the ramped period.

Ports:
- `clk`, in, 1: clock.
- `n_rst`, in, 1: reset, asynchronous, active-low.
- `mode`, in, 3: current game mode.
- `btn_up`, in, 1: raw button that raises the level; asynchronous to clk.
- `btn_down`, in, 1: raw button that lowers the level; asynchronous to clk.
- `play`, in, 1: high while the game is running.
- `hit`, in, 1: one-cycle pulse for a note hit.
- `miss`, in, 1: one-cycle pulse for a note miss.
- `level`, out, `$clog2(NUM_LEVELS+1)`: current level, range 1..`NUM_LEVELS`.
- `diff_speed`, out, `SPEED_W`: effective tick period in clk cycles.
- `tick`, out, 1: one-cycle beat pulse.

## Operation
- **Button conditioning.** Each button goes through a 2-flop synchroniser followed by rising-edge detection, which yields a one-cycle `up_p`/`dn_p`.
- **Level update.** The level changes only when `mode==DIFF_MODE`.
  - `up_p`: level+1. At `NUM_LEVELS` it goes to 1 if `WRAP`, otherwise it holds.
  - `dn_p`: level−1. At 1 it goes to `NUM_LEVELS` if `WRAP`, otherwise it holds.
  - `up_p` and `dn_p` in the same cycle: no change.
  - Edges that occur outside `DIFF_MODE` are discarded, not queued.
- **Table speed.** `tbl_speed = BASE_SPEED - (level-1)*SPEED_STEP`, computed at `SPEED_W` width with no overflow possible, given the elaboration check.
- **Ramp.** A streak counter (0..`STREAK_LEN`-1) and a ramp-step counter are active only while `play=1`.
  - `hit` increments the streak. When the streak reaches `STREAK_LEN`, it clears and the ramp step increments.
  - `miss` clears both the streak and the ramp step. If `hit` and `miss` arrive in the same cycle, `miss` wins.
  - Any level change, or `play=0`, clears both counters.
  - The ramp-step counter saturates once the floor is reached.
  - `diff_speed = max(tbl_speed - ramp*RAMP_STEP, MIN_SPEED)`. The subtraction is evaluated wide or guarded so it never underflows. If `MIN_SPEED > tbl_speed`, `diff_speed = tbl_speed`.
- **Tick generator.** The period counter (`SPEED_W` bits) runs only while `play=1`.
  - While `cnt >= diff_speed-1`: `tick=1` and `cnt` goes to 0.
  - Otherwise `cnt` increments.
  - `play=0` forces `cnt=0` and `tick=0`.
  - A period shrinking below the current count therefore fires `tick` on the next cycle, then restarts the count.

## Timing
- **Reset values.** `level=1`, `diff_speed=BASE_SPEED`, `tick=0`. All counters, synchroniser flops and edge flops are 0. Reset mid-game aborts the ramp and the tick count immediately.
- **Button latency.** If `btn_up` is first sampled high at edge E0, `level` changes at edge E2, and `diff_speed` follows combinationally in the same cycle. A held button produces exactly one step.
- **Hit latency.** A `hit` that completes a streak at edge E updates the ramp register at E, so `diff_speed` reflects it after E.
- **Tick timing.** `tick` is registered. With a constant period P, the first tick comes P cycles after `play` rises, then one every P cycles.
- **Throughput.** `hit`/`miss` are accepted every cycle.

## Configuration
- Macro: `DIFF_AUTO_RAMP_EN`.
- **Defined:** ramp behaviour as above.
- **Undefined:**
  - No streak or ramp registers are built.
  - `hit`/`miss` are ignored; the ports remain for a fixed interface.
  - `diff_speed = tbl_speed` always.
  - The tick generator is unchanged.

## Test plan
All scenarios use default parameters.
- **Reset.** Assert `n_rst=0` mid-operation → `level=1`, `diff_speed=6000000`, `tick=0`, and the next tick comes 6000000 cycles after `play`.
- **Level cycling.** `mode=3`, three `btn_up` presses → `level` 2,3,1 and `diff_speed` 4000000, 2000000, 6000000. Repeat with `WRAP=0` → `level` sticks at 3.
- **Mode gating and simultaneity.**
  - `mode=1`, press `btn_up` → `level` unchanged.
  - `mode=3`, `btn_up` and `btn_down` rising in the same cycle → unchanged.
  - Holding `btn_down` for 100 cycles → exactly one decrement.
- **Ramp.** `level=1`, `play=1`, 16 hits → `diff_speed` 5750000 then 5500000. One `miss` → 6000000.
- **Floor.** `level=3`, 8 hits → 1750000. Further streaks → floor at 1000000. `hit` and `miss` in the same cycle → 2000000.
- **Tick period change.** Override `BASE_SPEED=20`, `SPEED_STEP=5`:
  - Ticks every 20 cycles.
  - Switching to level 3 with `cnt=15` → tick on the next cycle, then every 10.
  - `play=0` → no ticks and `cnt` cleared.

Source files
------------

// File: rtl/diff_ctrl.sv
// diff_ctrl
//   Difficulty and tempo controller for the game core. Holds an N-level
//   difficulty table selected with up/down buttons (only in DIFF_MODE),
//   derives the beat period from the table, optionally tightens that period
//   on hit streaks while playing, and generates the one-cycle beat tick that
//   the note scroller consumes.
//
//   Optional feature macro: DIFF_AUTO_RAMP_EN
//     defined   - streak/ramp registers are built and shorten the period on
//                 hit streaks, down to MIN_SPEED.
//     undefined - hit/miss are ignored and diff_speed is the table speed.
//
// Ports
//   clk        in   clock
//   n_rst      in   asynchronous active-low reset
//   mode       in   [2:0] current game mode
//   btn_up     in   raw level-up button (asynchronous to clk)
//   btn_down   in   raw level-down button (asynchronous to clk)
//   play       in   high while the game is running
//   hit        in   one-cycle pulse per note hit
//   miss       in   one-cycle pulse per note miss
//   level      out  [$clog2(NUM_LEVELS+1)-1:0] current level, 1..NUM_LEVELS
//   diff_speed out  [SPEED_W-1:0] effective tick period in clk cycles
//   tick       out  one-cycle registered beat pulse

module diff_ctrl #(
  parameter int         NUM_LEVELS = 3,
  parameter int         SPEED_W    = 23,
  parameter int         BASE_SPEED = 6000000,
  parameter int         SPEED_STEP = 2000000,
  parameter int         WRAP       = 1,
  parameter logic [2:0] DIFF_MODE  = 3'd3,
  parameter int         STREAK_LEN = 8,
  parameter int         RAMP_STEP  = 250000,
  parameter int         MIN_SPEED  = 1000000
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [2:0]                        mode,
  input  logic                              btn_up,
  input  logic                              btn_down,
  input  logic                              play,
  input  logic                              hit,
  input  logic                              miss,
  output logic [$clog2(NUM_LEVELS+1)-1:0]   level,
  output logic [SPEED_W-1:0]                diff_speed,
  output logic                              tick
);

  localparam int LEVEL_W = $clog2(NUM_LEVELS + 1);
  localparam logic [LEVEL_W-1:0] LVL_ONE = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(NUM_LEVELS);

  // Configurations that would let the table speed reach zero or go negative
  // are rejected at elaboration.
  if (NUM_LEVELS < 2) begin : g_chk_levels
    $error("diff_ctrl: NUM_LEVELS must be at least 2");
  end
  if (longint'(BASE_SPEED) <= longint'(NUM_LEVELS - 1) * longint'(SPEED_STEP)) begin : g_chk_speed
    $error("diff_ctrl: BASE_SPEED must exceed (NUM_LEVELS-1)*SPEED_STEP");
  end

  logic up_s1, up_s2, up_d;
  logic dn_s1, dn_s2, dn_d;
  logic up_p, dn_p;
  logic [LEVEL_W-1:0] level_nxt;
  logic lvl_chg;
  logic [SPEED_W-1:0] tbl_speed;
  logic [SPEED_W-1:0] cnt;

  // Two-flop synchronisers plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      up_s1 <= 1'b0;
      up_s2 <= 1'b0;
      up_d  <= 1'b0;
      dn_s1 <= 1'b0;
      dn_s2 <= 1'b0;
      dn_d  <= 1'b0;
    end else begin
      up_s1 <= btn_up;
      up_s2 <= up_s1;
      up_d  <= up_s2;
      dn_s1 <= btn_down;
      dn_s2 <= dn_s1;
      dn_d  <= dn_s2;
    end
  end

  assign up_p = up_s2 & ~up_d;
  assign dn_p = dn_s2 & ~dn_d;

  // Edges seen outside DIFF_MODE fall through here and are simply lost.
  always_comb begin
    level_nxt = level;
    if ((mode == DIFF_MODE) && (up_p ^ dn_p)) begin
      if (up_p) begin
        if (level == LVL_MAX) begin
          level_nxt = (WRAP != 0) ? LVL_ONE : level;
        end else begin
          level_nxt = level + LVL_ONE;
        end
      end else begin
        if (level == LVL_ONE) begin
          level_nxt = (WRAP != 0) ? LVL_MAX : level;
        end else begin
          level_nxt = level - LVL_ONE;
        end
      end
    end
  end

  assign lvl_chg = (level_nxt != level);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      level <= LVL_ONE;
    end else begin
      level <= level_nxt;
    end
  end

  // level >= 1 always, so (level-1) never wraps.
  assign tbl_speed = SPEED_W'(BASE_SPEED)
                   - SPEED_W'(level - LVL_ONE) * SPEED_W'(SPEED_STEP);

`ifdef DIFF_AUTO_RAMP_EN

  localparam int STREAK_W = $clog2(STREAK_LEN + 1);
  localparam int WIDE_W   = SPEED_W + 32;
  localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(STREAK_LEN - 1);

  logic [STREAK_W-1:0] streak;
  logic [SPEED_W-1:0]  ramp;
  logic [WIDE_W-1:0]   ramp_red;
  logic [WIDE_W-1:0]   tbl_wide;
  logic [WIDE_W-1:0]   min_wide;
  logic                at_floor;

  // The reduction is compared in a wider domain so the subtraction below is
  // only ever taken when it cannot underflow.
  assign ramp_red = WIDE_W'(ramp) * WIDE_W'(RAMP_STEP);
  assign tbl_wide = WIDE_W'(tbl_speed);
  assign min_wide = WIDE_W'(MIN_SPEED);
  assign at_floor = (ramp_red + min_wide) >= tbl_wide;

  always_comb begin
    diff_speed = tbl_speed;
    if (min_wide > tbl_wide) begin
      diff_speed = tbl_speed;
    end else if (at_floor) begin
      diff_speed = SPEED_W'(MIN_SPEED);
    end else begin
      diff_speed = tbl_speed - SPEED_W'(ramp_red);
    end
  end

  // Miss has priority over hit; the ramp step stops counting once the
  // period is already pinned at the floor.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      streak <= '0;
      ramp   <= '0;
    end else if (!play || lvl_chg || miss) begin
      streak <= '0;
      ramp   <= '0;
    end else if (hit) begin
      if (streak == STREAK_LAST) begin
        streak <= '0;
        if (!at_floor) begin
          ramp <= ramp + SPEED_W'(1);
        end
      end else begin
        streak <= streak + STREAK_W'(1);
      end
    end
  end

`else

  logic unused_ramp_inputs;

  assign unused_ramp_inputs = hit ^ miss;
  assign diff_speed         = tbl_speed;

`endif

  // Using >= rather than == means a period that shrinks below the running
  // count fires on the next cycle instead of waiting for a wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!play) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= (diff_speed - SPEED_W'(1))) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + SPEED_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diff_ctrl.sv
// tb_diff_ctrl
//   Directed bench for diff_ctrl. Three instances share the clock/reset:
//   dut (defaults), dut_nw (WRAP=0, sharing dut's inputs) and dut_f
//   (BASE_SPEED=20, SPEED_STEP=5, own inputs) for tick-period checks.
//   Ramp expectations follow DIFF_AUTO_RAMP_EN the same way the design does.

module tb_diff_ctrl;

`ifdef DIFF_AUTO_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  logic        clk;
  logic        n_rst;
  logic [2:0]  mode;
  logic        btn_up, btn_down, play, hit, miss;
  logic [1:0]  level, level_nw;
  logic [22:0] diff_speed, diff_speed_nw;
  logic        tick, tick_nw;

  logic [2:0]  mode_f;
  logic        btn_up_f, btn_down_f, play_f, hit_f, miss_f;
  logic [1:0]  level_f;
  logic [22:0] diff_speed_f;
  logic        tick_f;

  int vectors     = 0;
  int miscompares = 0;

  diff_ctrl dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .btn_up(btn_up), .btn_down(btn_down),
    .play(play), .hit(hit), .miss(miss),
    .level(level), .diff_speed(diff_speed), .tick(tick)
  );

  diff_ctrl #(.WRAP(0)) dut_nw (
    .clk(clk), .n_rst(n_rst), .mode(mode), .btn_up(btn_up), .btn_down(btn_down),
    .play(play), .hit(hit), .miss(miss),
    .level(level_nw), .diff_speed(diff_speed_nw), .tick(tick_nw)
  );

  diff_ctrl #(.BASE_SPEED(20), .SPEED_STEP(5)) dut_f (
    .clk(clk), .n_rst(n_rst), .mode(mode_f), .btn_up(btn_up_f), .btn_down(btn_down_f),
    .play(play_f), .hit(hit_f), .miss(miss_f),
    .level(level_f), .diff_speed(diff_speed_f), .tick(tick_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(2);
    vectors++;
    if (level !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL reset_level: got %0d, expected %0d", level, 1);
    end
    vectors++;
    if (diff_speed !== 23'd6000000) begin
      miscompares++;
      $display("[TB] FAIL reset_speed: got %0d, expected %0d", diff_speed, 6000000);
    end
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_tick: got %0d, expected %0d", tick, 0);
    end
    vectors++;
    if (diff_speed_f !== 23'd20) begin
      miscompares++;
      $display("[TB] FAIL reset_speed_fast: got %0d, expected %0d", diff_speed_f, 20);
    end
    n_rst = 1'b1;
    mode  = 3'd3;
    btn_up = 1'b1;
    step(1);
    btn_up = 1'b0;
    step(2);
    vectors++;
    if (level !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_level: got %0d, expected %0d", level, 2);
    end
    play   = 1'b1;
    play_f = 1'b1;
    step(27);
    n_rst = 1'b0;
    #1;
    vectors++;
    if (level !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL midgame_reset_level: got %0d, expected %0d", level, 1);
    end
    vectors++;
    if (diff_speed !== 23'd6000000) begin
      miscompares++;
      $display("[TB] FAIL midgame_reset_speed: got %0d, expected %0d", diff_speed, 6000000);
    end
    vectors++;
    if (tick_f !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midgame_reset_tick: got %0d, expected %0d", tick_f, 0);
    end
    step(2);
    n_rst = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      vectors++;
      if (tick_f !== (k == 20)) begin
        miscompares++;
        $display("[TB] FAIL post_reset_tick k=%0d: got %0d, expected %0d", k, tick_f, (k == 20));
      end
    end
    play   = 1'b0;
    play_f = 1'b0;
    step(2);
  endtask

  task automatic test_level_cycling;
    int exp_lvl[3]    = '{2, 3, 1};
    int exp_spd[3]    = '{4000000, 2000000, 6000000};
    int exp_lvl_nw[3] = '{2, 3, 3};
    mode = 3'd3;
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'b1;
      step(1);
      btn_up = 1'b0;
      step(2);
      vectors++;
      if (level !== 2'(exp_lvl[i])) begin
        miscompares++;
        $display("[TB] FAIL cycle_level[%0d]: got %0d, expected %0d", i, level, exp_lvl[i]);
      end
      vectors++;
      if (diff_speed !== 23'(exp_spd[i])) begin
        miscompares++;
        $display("[TB] FAIL cycle_speed[%0d]: got %0d, expected %0d", i, diff_speed, exp_spd[i]);
      end
      vectors++;
      if (level_nw !== 2'(exp_lvl_nw[i])) begin
        miscompares++;
        $display("[TB] FAIL nowrap_level[%0d]: got %0d, expected %0d", i, level_nw, exp_lvl_nw[i]);
      end
      step(2);
    end
  endtask

  task automatic test_mode_gating;
    mode   = 3'd1;
    btn_up = 1'b1;
    step(1);
    btn_up = 1'b0;
    step(2);
    vectors++;
    if (level !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL gate_wrong_mode: got %0d, expected %0d", level, 1);
    end
    mode = 3'd3;
    step(3);
    vectors++;
    if (level !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL gate_not_queued: got %0d, expected %0d", level, 1);
    end
    btn_up   = 1'b1;
    btn_down = 1'b1;
    step(1);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(2);
    vectors++;
    if (level !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL simultaneous: got %0d, expected %0d", level, 1);
    end
    step(2);
    btn_down = 1'b1;
    step(100);
    vectors++;
    if (level !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL held_down: got %0d, expected %0d", level, 3);
    end
    vectors++;
    if (level_nw !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL held_down_nowrap: got %0d, expected %0d", level_nw, 2);
    end
    btn_down = 1'b0;
    step(3);
    btn_up = 1'b1;
    step(1);
    btn_up = 1'b0;
    step(2);
    vectors++;
    if (level !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL wrap_up_to_1: got %0d, expected %0d", level, 1);
    end
    step(2);
  endtask

  task automatic test_ramp;
    play = 1'b1;
    step(2);
    hit = 1'b1;
    step(7);
    vectors++;
    if (diff_speed !== 23'd6000000) begin
      miscompares++;
      $display("[TB] FAIL ramp_7_hits: got %0d, expected %0d", diff_speed, 6000000);
    end
    step(1);
    vectors++;
    if (diff_speed !== (RAMP_ON ? 23'd5750000 : 23'd6000000)) begin
      miscompares++;
      $display("[TB] FAIL ramp_8_hits: got %0d, expected %0d", diff_speed,
               RAMP_ON ? 5750000 : 6000000);
    end
    step(8);
    vectors++;
    if (diff_speed !== (RAMP_ON ? 23'd5500000 : 23'd6000000)) begin
      miscompares++;
      $display("[TB] FAIL ramp_16_hits: got %0d, expected %0d", diff_speed,
               RAMP_ON ? 5500000 : 6000000);
    end
    hit  = 1'b0;
    miss = 1'b1;
    step(1);
    miss = 1'b0;
    vectors++;
    if (diff_speed !== 23'd6000000) begin
      miscompares++;
      $display("[TB] FAIL ramp_miss: got %0d, expected %0d", diff_speed, 6000000);
    end
  endtask

  task automatic test_floor;
    int chunk[4]   = '{8, 8, 16, 16};
    int exp_on[4]  = '{1750000, 1500000, 1000000, 1000000};
    btn_down = 1'b1;
    step(1);
    btn_down = 1'b0;
    step(2);
    vectors++;
    if (level !== 2'd3 || diff_speed !== 23'd2000000) begin
      miscompares++;
      $display("[TB] FAIL floor_level3: got level %0d speed %0d, expected level 3 speed 2000000",
               level, diff_speed);
    end
    step(2);
    hit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(chunk[i]);
      vectors++;
      if (diff_speed !== (RAMP_ON ? 23'(exp_on[i]) : 23'd2000000)) begin
        miscompares++;
        $display("[TB] FAIL floor_step[%0d]: got %0d, expected %0d", i, diff_speed,
                 RAMP_ON ? exp_on[i] : 2000000);
      end
    end
    miss = 1'b1;
    step(1);
    miss = 1'b0;
    hit  = 1'b0;
    vectors++;
    if (diff_speed !== 23'd2000000) begin
      miscompares++;
      $display("[TB] FAIL hit_and_miss: got %0d, expected %0d", diff_speed, 2000000);
    end
    hit = 1'b1;
    step(8);
    hit = 1'b0;
    vectors++;
    if (diff_speed !== (RAMP_ON ? 23'd1750000 : 23'd2000000)) begin
      miscompares++;
      $display("[TB] FAIL floor_restreak: got %0d, expected %0d", diff_speed,
               RAMP_ON ? 1750000 : 2000000);
    end
    play = 1'b0;
    step(1);
    vectors++;
    if (diff_speed !== 23'd2000000) begin
      miscompares++;
      $display("[TB] FAIL play_low_clears: got %0d, expected %0d", diff_speed, 2000000);
    end
  endtask

  task automatic test_tick_period;
    bit exp_tick;
    mode_f = 3'd3;
    play_f = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      btn_down_f = (k >= 53 && k <= 60);
      step(1);
      exp_tick = (k == 20 || k == 40 || k == 56 || k == 66 || k == 76 || k == 86);
      vectors++;
      if (tick_f !== exp_tick) begin
        miscompares++;
        $display("[TB] FAIL tick_period k=%0d: got %0d, expected %0d", k, tick_f, exp_tick);
      end
      if (k == 54 || k == 55 || k == 90) begin
        vectors++;
        if (level_f !== ((k == 54) ? 2'd1 : 2'd3) ||
            diff_speed_f !== ((k == 54) ? 23'd20 : 23'd10)) begin
          miscompares++;
          $display("[TB] FAIL tick_level k=%0d: got level %0d speed %0d, expected level %0d speed %0d",
                   k, level_f, diff_speed_f, (k == 54) ? 1 : 3, (k == 54) ? 20 : 10);
        end
      end
    end
    btn_down_f = 1'b0;
    play_f     = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      vectors++;
      if (tick_f !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL tick_play_low k=%0d: got %0d, expected %0d", k, tick_f, 0);
      end
    end
    play_f = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      exp_tick = (k == 10 || k == 20);
      vectors++;
      if (tick_f !== exp_tick) begin
        miscompares++;
        $display("[TB] FAIL tick_restart k=%0d: got %0d, expected %0d", k, tick_f, exp_tick);
      end
    end
    play_f = 1'b0;
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_rst      = 1'b0;
    mode       = 3'd0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    play       = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    mode_f     = 3'd3;
    btn_up_f   = 1'b0;
    btn_down_f = 1'b0;
    play_f     = 1'b0;
    hit_f      = 1'b0;
    miss_f     = 1'b0;
    test_reset();
    test_level_cycling();
    test_mode_gating();
    test_ramp();
    test_floor();
    test_tick_period();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
